// File: rtl/fsm_secure_pkg.sv
// Shared definitions for the hardened A/B/C/D control FSM: redundant state
// codes, the 2-bit external state code and the legality check.
package fsm_secure_pkg;

    // Legal state codes are pairwise at least two bits apart, so a single
    // upset can never turn one legal state into another.
    typedef enum logic [3:0] {
        ST_S0    = 4'b0000,
        ST_S1    = 4'b0011,
        ST_S2    = 4'b0101,
        ST_S3    = 4'b0110,
        ST_FAULT = 4'b1111
    } state_e;

    localparam logic [1:0] OUT_S0    = 2'b00;
    localparam logic [1:0] OUT_S1    = 2'b01;
    localparam logic [1:0] OUT_S2    = 2'b10;
    localparam logic [1:0] OUT_S3    = 2'b11;
    localparam logic [1:0] OUT_FAULT = 2'b00;

    // True only for one of the five defined codes.
    function automatic logic is_legal_state(input logic [3:0] st);
        case (st)
            ST_S0, ST_S1, ST_S2, ST_S3, ST_FAULT: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    // External 2-bit code for a state; FAULT and anything unknown read as 00.
    function automatic logic [1:0] out_code(input logic [3:0] st);
        case (st)
            ST_S0:    return OUT_S0;
            ST_S1:    return OUT_S1;
            ST_S2:    return OUT_S2;
            ST_S3:    return OUT_S3;
            ST_FAULT: return OUT_FAULT;
            default:  return OUT_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/fsm_sat_cnt.sv
// Saturating up-counter with synchronous reset, synchronous clear and enable.
// Clear wins over enable; the count holds once it reaches MAX.
module fsm_sat_cnt #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] L_MAX  = W'(MAX);
    localparam logic [W-1:0] L_ONE  = W'(1);
    localparam logic [W-1:0] L_ZERO = W'(0);

    // Count register: reset/clear to zero, otherwise step until saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_cnt <= L_ZERO;
        end else if (i_clr) begin
            o_cnt <= L_ZERO;
        end else if (i_en && (o_cnt != L_MAX)) begin
            o_cnt <= o_cnt + L_ONE;
        end else begin
            o_cnt <= o_cnt;
        end
    end

endmodule

// File: rtl/fsm_secure_ctrl.sv
// Hardened A/B/C/D control FSM. Keeps the S0..S3 graph and 2-bit output code,
// adds a bounded S1 dwell, a conflict counter that trips a sticky FAULT state,
// and detection of corrupted state codes. All outputs are registered.
module fsm_secure_ctrl #(
    parameter int HOLD_MAX = 16,
    parameter int CONF_MAX = 3,
    parameter int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1,
    parameter int CONF_W   = $clog2(CONF_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              A,
    input  logic              B,
    input  logic              C,
    input  logic              D,
    output logic [1:0]        out,
    output logic              fault,
    output logic [CONF_W-1:0] conflict_cnt,
    output logic [HOLD_W-1:0] dwell
);

    import fsm_secure_pkg::*;

    localparam logic [HOLD_W-1:0] L_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [CONF_W-1:0] L_CONF_LAST = CONF_W'(CONF_MAX - 1);

    logic [3:0] r_state;
    logic [1:0] r_out;
    logic       r_fault;
    logic [3:0] w_next;
    logic       w_conflict;
    logic       w_legal;
    logic       w_dwell_clr;
    logic       w_dwell_en;

    // Next-state decode: corrupted code first, then conflict limit, then graph.
    always_comb begin
        w_next     = r_state;
        w_conflict = 1'b0;
        w_legal    = is_legal_state(r_state);
        if (!w_legal) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_S0: begin
                    if (B && C) begin
                        w_conflict = 1'b1;
                        if (conflict_cnt == L_CONF_LAST) begin
                            w_next = ST_FAULT;
                        end else begin
                            w_next = ST_S0;
                        end
                    end else if (B) begin
                        w_next = ST_S1;
                    end else if (C) begin
                        w_next = ST_S2;
                    end else begin
                        w_next = ST_S0;
                    end
                end
                ST_S1: begin
                    // Release request and timeout both lead home.
                    if (D || (dwell == L_HOLD_LAST)) begin
                        w_next = ST_S0;
                    end else begin
                        w_next = ST_S1;
                    end
                end
                ST_S2: begin
                    if (A && B) begin
                        w_conflict = 1'b1;
                        if (conflict_cnt == L_CONF_LAST) begin
                            w_next = ST_FAULT;
                        end else begin
                            w_next = ST_S2;
                        end
                    end else if (B) begin
                        w_next = ST_S1;
                    end else if (A) begin
                        w_next = ST_S3;
                    end else begin
                        w_next = ST_S2;
                    end
                end
                ST_S3: begin
                    if (!A) begin
                        w_next = ST_S2;
                    end else begin
                        w_next = ST_S3;
                    end
                end
                ST_FAULT: begin
                    w_next = ST_FAULT;
                end
                default: begin
                    w_next = ST_FAULT;
                end
            endcase
        end
    end

    // Dwell counter control: zero on any edge not landing in S1, step while staying.
    always_comb begin
        w_dwell_clr = (w_next != ST_S1);
        w_dwell_en  = (r_state == ST_S1) && (w_next == ST_S1);
    end

    // State register with registered output code and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_S0;
            r_out   <= OUT_S0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= out_code(w_next);
            r_fault <= r_fault | (w_next == ST_FAULT);
        end
    end

    assign out   = r_out;
    assign fault = r_fault;

    fsm_sat_cnt #(
        .W   (HOLD_W),
        .MAX (HOLD_MAX - 1)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_dwell_clr),
        .i_en  (w_dwell_en),
        .o_cnt (dwell)
    );

    // The conflict count is only ever cleared by reset; in FAULT no conflict
    // is decoded, so the count stays frozen there.
    fsm_sat_cnt #(
        .W   (CONF_W),
        .MAX (CONF_MAX)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_en  (w_conflict),
        .o_cnt (conflict_cnt)
    );

endmodule

// File: tb/tb_fsm_secure_ctrl.sv
// Bench for fsm_secure_ctrl: directed walk through the main scenarios followed
// by random stimulus, all checked against a state-index level reference model.
module tb_fsm_secure_ctrl;

    localparam int HOLD_MAX = 4;
    localparam int CONF_MAX = 3;
    localparam int HOLD_W   = 2;
    localparam int CONF_W   = 2;

    logic              clk;
    logic              rst;
    logic              A, B, C, D;
    logic [1:0]        out;
    logic              fault;
    logic [CONF_W-1:0] conflict_cnt;
    logic [HOLD_W-1:0] dwell;

    int checks   = 0;
    int failures = 0;

    // Reference model: state index 0..3 for S0..S3, plus a fault flag.
    int m_st     = 0;
    int m_dwell  = 0;
    int m_conf   = 0;
    bit m_fault  = 1'b0;
    bit m_inject = 1'b0;

    fsm_secure_ctrl #(
        .HOLD_MAX (HOLD_MAX),
        .CONF_MAX (CONF_MAX),
        .HOLD_W   (HOLD_W),
        .CONF_W   (CONF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .out          (out),
        .fault        (fault),
        .conflict_cnt (conflict_cnt),
        .dwell        (dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_step(input bit a, input bit b, input bit c, input bit d, input bit r);
        if (r) begin
            m_st = 0; m_dwell = 0; m_conf = 0; m_fault = 1'b0;
        end else if (m_inject) begin
            m_fault = 1'b1; m_dwell = 0;
        end else if (!m_fault) begin
            case (m_st)
                0: if (b && c) begin
                       m_conf++;
                       if (m_conf == CONF_MAX) m_fault = 1'b1;
                   end else if (b) m_st = 1;
                   else if (c) m_st = 2;
                1: if (d || m_dwell == HOLD_MAX - 1) begin
                       m_st = 0; m_dwell = 0;
                   end else m_dwell++;
                2: if (a && b) begin
                       m_conf++;
                       if (m_conf == CONF_MAX) m_fault = 1'b1;
                   end else if (b) m_st = 1;
                   else if (a) m_st = 3;
                default: if (!a) m_st = 2;
            endcase
        end
        m_inject = 1'b0;
    endtask

    // Drive inputs, take one edge, advance the model, compare all outputs.
    task automatic step(input bit a, input bit b, input bit c, input bit d, input bit r,
                        input string tag);
        A = a; B = b; C = c; D = d; rst = r;
        @(posedge clk);
        model_step(a, b, c, d, r);
        #1;
        chk({tag, "_out"},   32'(out),          32'(m_fault ? 0 : m_st));
        chk({tag, "_fault"}, 32'(fault),        32'(m_fault));
        chk({tag, "_conf"},  32'(conflict_cnt), 32'(m_conf));
        chk({tag, "_dwell"}, 32'(dwell),        32'(m_dwell));
    endtask

    initial begin
        int n;
        A = 1'b0; B = 1'b0; C = 1'b0; D = 1'b0; rst = 1'b1;
        #1;

        // 1. reset then S0 -> S1 with dwell counting
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst0");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rst1");
        chk("rst_out_const", 32'(out), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "enter_s1");
        chk("enter_s1_const", 32'(out), 32'd1);

        // 2. timeout: S1 lasts exactly HOLD_MAX cycles without D
        n = 1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "timeout");
            if (out == 2'b01) n++;
        end
        chk("s1_len", 32'(n), 32'd4);
        chk("timeout_out", 32'(out), 32'd0);

        // 2b. D in the second S1 cycle releases at once
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rel_enter");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rel_hold");
        chk("rel_dwell", 32'(dwell), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rel_d");
        chk("rel_out", 32'(out), 32'd0);

        // 3. S0 -> S2 -> S3 -> S2 -> S1
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "path_s2");
        chk("path_s2_const", 32'(out), 32'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "path_s3");
        chk("path_s3_const", 32'(out), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "path_back");
        chk("path_back_const", 32'(out), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "path_s1");
        chk("path_s1_const", 32'(out), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "path_home");

        // 4. three non-consecutive conflicts trip FAULT
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "conf1");
        chk("conf1_const", 32'(conflict_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "conf2");
        chk("conf2_const", 32'(conflict_cnt), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap2");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "conf3");
        chk("conf3_fault", 32'(fault), 32'd1);
        chk("conf3_cnt", 32'(conflict_cnt), 32'd3);
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "fault_hold");
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fault_rst");

        // 5. corrupted state code goes to FAULT on the next edge
        force dut.r_state = 4'b0001;
        m_inject = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "illegal");
        release dut.r_state;
        chk("illegal_fault", 32'(fault), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "illegal_hold");
        chk("illegal_state", 32'(dut.r_state), 32'hF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "illegal_rst");
        chk("illegal_rst_fault", 32'(fault), 32'd0);

        // 6. reset in S1 at dwell 2, then a full fresh dwell
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mid_enter");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_d1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_d2");
        chk("mid_dwell2", 32'(dwell), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "mid_rst");
        chk("mid_rst_dwell", 32'(dwell), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "re_enter");
        n = 1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "re_hold");
            if (out == 2'b01) n++;
        end
        chk("re_s1_len", 32'(n), 32'd4);

        // Random stimulus with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_secure_ctrl.md
# fsm_secure_ctrl

- Parametrised, hardened successor to the group's 4-state A/B/C/D control FSM.
- Keeps the S0/S1/S2/S3 transition graph and output coding, and adds:
  - a timed and commanded exit from the former S1 dead-end;
  - redundant state encoding with illegal-state detection;
  - a saturating conflicting-input counter;
  - a sticky FAULT state.
- Sits between the input-conditioning logic and the security-verification checkers; every output is registered.

## Interface

Parameters:
- HOLD_MAX, 16: cycles S1 may be occupied before a forced return to S0; must be ≥ 1.
- CONF_MAX, 3: number of conflict cycles that drives the FSM into FAULT; must be ≥ 1.
- HOLD_W, $clog2(HOLD_MAX): width of the S1 dwell counter; min 1.
- CONF_W, $clog2(CONF_MAX+1): width of the conflict counter.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- A, B, C, D  in  1 each  control inputs; D is the S1 release request.
- out  out  2  current state code: S0=00, S1=01, S2=10, S3=11; 00 in FAULT.
- fault  out  1  sticky fault flag.
- conflict_cnt  out  CONF_W  saturating count of conflict cycles.
- dwell  out  HOLD_W  S1 dwell counter; 0 outside S1.

## Operation

State register is 4 bits. Legal codes (pairwise Hamming distance ≥ 2):
- S0=0000, S1=0011, S2=0101, S3=0110, FAULT=1111.
- Any other value is illegal. On the next edge it goes to FAULT and sets fault=1.

Transitions (evaluated from the registered state; inputs sampled at the edge):
- **S0**
  - B & !C → S1.
  - C & !B → S2.
  - B & C → conflict cycle; stay in S0.
  - otherwise stay.
- **S1**
  - D=1 → S0.
  - dwell == HOLD_MAX-1 → S0 (timeout).
  - Both conditions give S0; no priority question arises.
  - otherwise stay, dwell += 1.
- **S2**
  - B & !A → S1.
  - A & !B → S3.
  - A & B → conflict cycle; stay in S2.
  - otherwise stay.
- **S3**
  - A=0 → S2.
  - otherwise stay.
- **FAULT**
  - Absorbing; only rst exits.
  - Inputs are ignored; conflict_cnt and dwell are frozen.

Counters:
- **dwell**
  - Cleared on every edge whose next state is not S1, so it is 0 on S1 entry.
  - Increments each cycle spent in S1; never exceeds HOLD_MAX-1.
- **conflict_cnt**
  - Increments on the edge following each conflict cycle; saturates at CONF_MAX.
  - Never cleared except by rst.
  - On the edge where it reaches CONF_MAX, the state goes to FAULT and fault=1.

Precedence on a single edge: rst > illegal-state → FAULT > conflict-limit → FAULT > normal transition.

## Timing

- Reset values (synchronous: apply on the first rising edge with rst=1):
  - state=S0, out=00, fault=0, conflict_cnt=0, dwell=0.
- rst asserted mid-operation, including in FAULT, forces the reset values on that edge, whatever the other inputs are.
- out, fault, conflict_cnt and dwell all update on the same edge as the state; latency from input to out is 1 cycle.
- S1 occupancy without D is exactly HOLD_MAX cycles.
- HOLD_MAX=1: S1 lasts exactly one cycle.
- Conflict FAULT timing: the CONF_MAX-th conflict cycle in sample cycle n gives state=FAULT at edge n+1.
- Conflict cycles need not be consecutive.
- Illegal-state detection latency: 1 cycle from corruption to FAULT.

## Structure

- Package fsm_secure_pkg holds:
  - the 4-bit state codes, including FAULT;
  - the 2-bit out codes;
  - the legal-state check function.
- One sub-module, fsm_sat_cnt (parametrised width/max, synchronous clear, enable, saturation), instantiated twice: once for dwell, once for conflict_cnt.
- Next-state decode and output decode live in the top module.

## Test plan

1. **Reset and basic path.** rst 2 cycles; then B=1, C=0.
   - Required: out=00 during reset, then out=01 one edge later, dwell counts 0,1,2…
2. **S1 timeout**, HOLD_MAX=4, D=0.
   - Required: out=01 for exactly 4 cycles, then 00.
   - Repeat with D=1 in the second S1 cycle: out=00 on the next edge.
3. **S0→S2→S3→S2→S1 path.**
   - Stimulus: C=1; then A=1; then A=0; then B=1, A=0.
   - Required: out = 10, 11, 10, 01 on successive edges.
4. **Conflict limit**, CONF_MAX=3. Apply B=C=1 in S0 on three non-consecutive cycles.
   - Required: conflict_cnt 1, 2, 3; fault=1 and out=00 at the edge after the third.
   - Required: inputs then have no effect until rst.
5. **Illegal state.** Force state to 0001 for one cycle.
   - Required: fault=1 and state 1111 on the next edge.
   - Required: rst restores S0, fault=0, conflict_cnt=0.
6. **Reset mid-S1**, dwell=2, with D=0.
   - Required: after the rst edge, out=00 and dwell=0.
   - Required: re-entering S1 restarts the full HOLD_MAX count.
